// File: rtl/edf_dispatcher.sv
// Earliest-deadline-first dispatcher: load 1 cycle after accept, then 1 task/cycle while out_ready is held.
// in_ready drops when the table is full; the output register holds until out_ready. EDF_DROP_EXPIRED_EN drops expired tasks.
module edf_dispatcher #(
  parameter int MAX_TASKS = 8,
  parameter int ID_W      = 8,
  parameter int DL_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ID_W-1:0]                in_id,
  input  logic [DL_W-1:0]                in_deadline,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ID_W-1:0]                out_id,
  output logic                           out_late,
  output logic [$clog2(MAX_TASKS+1)-1:0] pending,
  output logic [DL_W-1:0]                time_now
`ifdef EDF_DROP_EXPIRED_EN
  ,
  output logic [15:0]                    drop_count
`endif
);
  localparam int CNT_W = $clog2(MAX_TASKS + 1);
  localparam int IDX_W = $clog2(MAX_TASKS);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t                state_q;
  logic [MAX_TASKS-1:0]  valid_q;
  logic [DL_W-1:0]       dl_q [MAX_TASKS];
  logic [ID_W-1:0]       id_q [MAX_TASKS];
  logic [CNT_W-1:0]      pending_q, pending_d;
  logic [DL_W-1:0]       time_q;
  logic [ID_W-1:0]       out_id_q;
  logic                  out_late_q;

  logic signed [DL_W-1:0] slack [MAX_TASKS];
  logic signed [DL_W-1:0] win_slack;
  logic [IDX_W-1:0]       win_idx, free_idx;
  logic                   win_vld, free_vld, drop_vld;
  logic                   accept, take, load;

  // Slack is the wrap-safe distance to the deadline; negative means overdue.
  always_comb begin
    for (int i = 0; i < MAX_TASKS; i++) begin
      slack[i] = dl_q[i] - time_q;
    end
  end

  always_comb begin
    win_idx   = '0;
    win_slack = '0;
    win_vld   = 1'b0;
    free_idx  = '0;
    free_vld  = 1'b0;
    for (int i = 0; i < MAX_TASKS; i++) begin
      if (valid_q[i] && (!win_vld || slack[i] < win_slack)) begin
        win_vld   = 1'b1;
        win_idx   = IDX_W'(i);
        win_slack = slack[i];
      end
      if (!valid_q[i] && !free_vld) begin
        free_vld = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

`ifdef EDF_DROP_EXPIRED_EN
  logic [IDX_W-1:0] drop_idx;
  logic [15:0]      drop_cnt_q;

  always_comb begin
    drop_idx = '0;
    drop_vld = 1'b0;
    for (int i = 0; i < MAX_TASKS; i++) begin
      if (valid_q[i] && slack[i][DL_W-1] && !drop_vld) begin
        drop_vld = 1'b1;
        drop_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop_vld && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_vld = 1'b0;
`endif

  assign in_ready  = (pending_q < CNT_W'(MAX_TASKS));
  assign accept    = in_valid && in_ready;
  assign take      = (state_q == EMPTY) || out_ready;
  // An expiry drop consumes the scheduler for that cycle, so no load alongside it.
  assign load      = take && win_vld && !drop_vld;
  assign pending_d = pending_q + CNT_W'(accept) - CNT_W'(load) - CNT_W'(drop_vld);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      valid_q    <= '0;
      pending_q  <= '0;
      time_q     <= '0;
      out_id_q   <= '0;
      out_late_q <= 1'b0;
    end else begin
      time_q    <= time_q + DL_W'(1);
      pending_q <= pending_d;
      if (accept) begin
        valid_q[free_idx] <= 1'b1;
        dl_q[free_idx]    <= time_q + in_deadline;
        id_q[free_idx]    <= in_id;
      end
`ifdef EDF_DROP_EXPIRED_EN
      if (drop_vld) begin
        valid_q[drop_idx] <= 1'b0;
      end
`endif
      if (load) begin
        valid_q[win_idx] <= 1'b0;
        out_id_q         <= id_q[win_idx];
`ifdef EDF_DROP_EXPIRED_EN
        out_late_q       <= 1'b0;
`else
        out_late_q       <= win_slack[DL_W-1];
`endif
        state_q          <= HOLD;
      end else if (out_ready) begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_id    = out_id_q;
  assign out_late  = out_late_q;
  assign pending   = pending_q;
  assign time_now  = time_q;

endmodule

// File: tb/tb_edf_dispatcher.sv
// Bench for edf_dispatcher: directed scenarios plus random traffic against a slot-table reference model.
module tb_edf_dispatcher;
  localparam int MAXT  = 8;
  localparam int IDW   = 8;
  localparam int DLW   = 16;
  localparam int CNTW  = $clog2(MAXT + 1);
  localparam int MOD   = 1 << DLW;
  localparam int HALF  = 1 << (DLW - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IDW-1:0]  in_id;
  logic [DLW-1:0]  in_deadline;
  logic            out_valid;
  logic            out_ready;
  logic [IDW-1:0]  out_id;
  logic            out_late;
  logic [CNTW-1:0] pending;
  logic [DLW-1:0]  time_now;
`ifdef EDF_DROP_EXPIRED_EN
  logic [15:0]     drop_count;
`endif

  always #5 clk = ~clk;

  edf_dispatcher #(.MAX_TASKS(MAXT), .ID_W(IDW), .DL_W(DLW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_deadline(in_deadline),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_late(out_late),
    .pending(pending), .time_now(time_now)
`ifdef EDF_DROP_EXPIRED_EN
    , .drop_count(drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a table of slots, the held output and the timer.
  bit m_v [MAXT];
  int m_id [MAXT];
  int m_dl [MAXT];
  bit m_ov;
  int m_oid;
  bit m_late;
  int m_time;
  int m_drops;

  int disp_q[$];
  int late_q[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int slack_of(input int dl, input int t);
    int d;
    d = (dl - t + MOD) % MOD;
    return (d >= HALF) ? d - MOD : d;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < MAXT; i++) c += m_v[i];
    return c;
  endfunction

  task automatic compare_all();
    int cnt;
    cnt = model_count();
    check_eq("time_now", int'(time_now), m_time);
    check_eq("pending", int'(pending), cnt);
    check_eq("in_ready", int'(in_ready), int'(cnt < MAXT));
    check_eq("out_valid", int'(out_valid), int'(m_ov));
    if (m_ov) begin
      check_eq("out_id", int'(out_id), m_oid);
      check_eq("out_late", int'(out_late), int'(m_late));
    end
`ifdef EDF_DROP_EXPIRED_EN
    check_eq("drop_count", int'(drop_count), m_drops);
`endif
  endtask

  // Drive one cycle, advance the model across the edge, then compare at the next negedge.
  task automatic step(input bit v, input int id, input int dl, input bit rdy, input bit rst);
    int cnt, fr, drop, w, ws;
    bit acc;
    if (out_valid && rdy && !rst) begin
      disp_q.push_back(int'(out_id));
      late_q.push_back(int'(out_late));
    end
    reset       = rst;
    in_valid    = v;
    in_id       = IDW'(id);
    in_deadline = DLW'(dl);
    out_ready   = rdy;
    if (rst) begin
      for (int i = 0; i < MAXT; i++) m_v[i] = 1'b0;
      m_ov = 1'b0; m_oid = 0; m_late = 1'b0; m_time = 0; m_drops = 0;
    end else begin
      cnt = model_count();
      fr = -1;
      for (int i = 0; i < MAXT; i++) if (!m_v[i] && fr < 0) fr = i;
      acc = v && (cnt < MAXT);
      drop = -1;
`ifdef EDF_DROP_EXPIRED_EN
      for (int i = 0; i < MAXT; i++)
        if (m_v[i] && slack_of(m_dl[i], m_time) < 0 && drop < 0) drop = i;
`endif
      w = -1; ws = 0;
      for (int i = 0; i < MAXT; i++)
        if (m_v[i] && (w < 0 || slack_of(m_dl[i], m_time) < ws)) begin
          w = i; ws = slack_of(m_dl[i], m_time);
        end
      if (drop >= 0) begin
        m_v[drop] = 1'b0;
        if (m_drops < 65535) m_drops++;
        if (m_ov && rdy) m_ov = 1'b0;
      end else if ((!m_ov || rdy) && w >= 0) begin
        m_oid = m_id[w]; m_late = (ws < 0); m_v[w] = 1'b0; m_ov = 1'b1;
      end else if (m_ov && rdy) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        m_v[fr] = 1'b1; m_id[fr] = id; m_dl[fr] = (m_time + dl) % MOD;
      end
      m_time = (m_time + 1) % MOD;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic submit(input int id, input int dl, input bit rdy);
    step(1'b1, id, dl, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, rdy, 1'b0);
  endtask

  int drops_before;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_id = '0; in_deadline = '0; out_ready = 1'b0;
    for (int i = 0; i < MAXT; i++) begin m_v[i] = 1'b0; m_id[i] = 0; m_dl[i] = 0; end
    m_ov = 1'b0; m_oid = 0; m_late = 1'b0; m_time = 0; m_drops = 0;
    @(negedge clk);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_out_id", int'(out_id), 0);
    check_eq("rst_out_late", int'(out_late), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_time", int'(time_now), 0);
    check_eq("rst_in_ready", int'(in_ready), 1);

    // Wrap-around: filler occupies the output, then 7 and 8 straddle the timer wrap.
    while (m_time != 16'hFFEE) step(1'b0, 0, 0, 1'b0, 1'b0);
    submit(8'hF0, 100, 1'b0);
    idle(1, 1'b0);
    check_eq("wrap_time", int'(time_now), 16'hFFF0);
    submit(7, 16'h20, 1'b0);
    submit(8, 16'h08, 1'b0);
    idle(1, 1'b0);
    disp_q.delete(); late_q.delete();
    idle(4, 1'b1);
    check_eq("wrap_count", disp_q.size(), 3);
    check_eq("wrap_first", disp_q[1], 8);
    check_eq("wrap_second", disp_q[2], 7);
    check_eq("wrap_late", late_q[1] + late_q[2], 0);

    // Order: 1,2,3 with deadlines 50,10,30 behind a held filler.
    submit(8'hF0, 200, 1'b0);
    idle(1, 1'b0);
    submit(1, 50, 1'b0);
    submit(2, 10, 1'b0);
    submit(3, 30, 1'b0);
    idle(1, 1'b0);
    disp_q.delete(); late_q.delete();
    idle(5, 1'b1);
    check_eq("order_count", disp_q.size(), 4);
    check_eq("order_0", disp_q[1], 2);
    check_eq("order_1", disp_q[2], 3);
    check_eq("order_2", disp_q[3], 1);
    check_eq("order_late", late_q[1] + late_q[2] + late_q[3], 0);
    check_eq("order_pending", int'(pending), 0);

    // Tie-break: equal absolute deadlines resolve to the lower slot.
    submit(8'hF0, 200, 1'b0);
    idle(1, 1'b0);
    submit(5, 20, 1'b0);
    submit(6, 19, 1'b0);
    idle(1, 1'b0);
    disp_q.delete(); late_q.delete();
    idle(4, 1'b1);
    check_eq("tie_first", disp_q[1], 5);
    check_eq("tie_second", disp_q[2], 6);

    // Full table and stall.
    for (int i = 0; i < 9; i++) submit(16 + i, 100 + i, 1'b0);
    check_eq("full_pending", int'(pending), 8);
    check_eq("full_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) submit(8'h19, 5, 1'b0);
    check_eq("stall_pending", int'(pending), 8);
    submit(8'h19, 5, 1'b1);
    check_eq("pulse_pending", int'(pending), 7);
    check_eq("pulse_in_ready", int'(in_ready), 1);
    submit(8'h19, 5, 1'b0);
    check_eq("refill_pending", int'(pending), 8);
    idle(12, 1'b1);

    // Late flag / expiry.
`ifdef EDF_DROP_EXPIRED_EN
    drops_before = int'(drop_count);
`else
    drops_before = 0;
`endif
    disp_q.delete(); late_q.delete();
    submit(9, 3, 1'b0);
    submit(10, 2, 1'b0);
    idle(10, 1'b0);
    idle(3, 1'b1);
    check_eq("late_first_id", disp_q[0], 9);
    check_eq("late_first_flag", late_q[0], 0);
`ifdef EDF_DROP_EXPIRED_EN
    check_eq("drop_delta", int'(drop_count) - drops_before, 1);
    check_eq("drop_disp_count", disp_q.size(), 1);
`else
    check_eq("late_second_id", disp_q[1], 10);
    check_eq("late_second_flag", late_q[1], 1);
    check_eq("late_drops", drops_before, 0);
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) < 45, int'($urandom_range(0, 255)),
           int'($urandom_range(0, 40)), $urandom_range(0, 99) < 35, 1'b0);
    end
    idle(20, 1'b1);

    // Reset in the middle of a handshake.
    for (int i = 0; i < 5; i++) submit(32 + i, 60 + i, 1'b0);
    check_eq("mid_out_valid", int'(out_valid), 1);
    check_eq("mid_pending", int'(pending), 4);
    step(1'b0, 0, 0, 1'b1, 1'b1);
    check_eq("mrst_out_valid", int'(out_valid), 0);
    check_eq("mrst_pending", int'(pending), 0);
    check_eq("mrst_time", int'(time_now), 0);
    check_eq("mrst_in_ready", int'(in_ready), 1);
    idle(3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/edf_dispatcher.md
Name: edf_dispatcher

Overview:
- Earliest-deadline-first dispatcher between the task-submission side and a single shared execution resource.
- Buffers up to MAX_TASKS pending tasks, each stamped with an absolute deadline from a free-running timer.
- Always hands the resource the pending task with the nearest deadline over a valid/ready handshake. Work-conserving: dispatch does not wait for the deadline to arrive.
- Flags tasks dispatched after their deadline.

Parameters:
- MAX_TASKS, 8, task table depth (2..32)
- ID_W, 8, task ID width
- DL_W, 16, timer and deadline width; relative deadlines must be < 2^(DL_W-1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  submit request
- in_ready  out  1  table can accept a task this cycle
- in_id  in  ID_W  task ID, opaque, stored as given
- in_deadline  in  DL_W  relative deadline in cycles
- out_valid  out  1  out_id/out_late hold a dispatched task
- out_ready  in  1  resource accepts the task
- out_id  out  ID_W  dispatched task ID
- out_late  out  1  task was past its deadline when loaded
- pending  out  $clog2(MAX_TASKS+1)  valid table entries, excluding the output register
- time_now  out  DL_W  free-running timer

Behaviour:
- Reset (synchronous): time_now=0, all slots invalid, pending=0, out_valid=0, out_id=0, out_late=0.
- Timer: time_now increments every cycle and wraps modulo 2^DL_W.
- Accept:
  - in_ready = (pending < MAX_TASKS), combinational from registered state only; no bypass when a slot frees in the same cycle.
  - On in_valid && in_ready, write the lowest-index free slot: abs_dl = (time_now + in_deadline) mod 2^DL_W, plus in_id.
- Wrap-safe compare: slack = signed(abs_dl - time_now), taken as DL_W-bit two's complement.
  - Winner = valid slot with minimum slack.
  - Ties go to the lowest index.
- Output register, FSM with states EMPTY and HOLD:
  - EMPTY: out_valid=0. If pending>0, load the winner into out_id, set out_late = (slack < 0), free its slot, go to HOLD.
  - HOLD: out_valid=1. out_id and out_late stay stable until out_ready.
    - On out_ready with pending>0, load the next winner in the same cycle and stay in HOLD, so back-to-back dispatches run at 1/cycle.
    - On out_ready with pending==0, go to EMPTY.
- Latency:
  - A task accepted in cycle N is eligible for winner selection from cycle N+1.
  - Earliest out_valid for that task is cycle N+2.
- Simultaneous accept and load:
  - pending_next = pending + accept − load.
  - The freed slot is reusable from the next cycle.
- Deadline edge cases:
  - in_deadline=0 gives slack=0 at the accept cycle.
  - out_late is set only when slack < 0 at the load cycle.
- Reset mid-handshake: out_valid drops the cycle after reset is asserted, and the task is lost.
- Out-of-range input: in_deadline >= 2^(DL_W-1) is a protocol violation; ordering is undefined.

Optional Feature:
- Macro: EDF_DROP_EXPIRED_EN
- Defined:
  - A valid slot whose slack < 0 is invalidated instead of dispatched.
  - The scheduler removes at most one expired slot per cycle: the lowest-index one.
  - That cycle's load is suppressed.
  - Adds output drop_count (16 bits), reset 0, +1 per drop, saturating at 0xFFFF.
  - out_late is then always 0.
- Undefined: expired tasks are dispatched normally with out_late=1, and drop_count is absent.

Test Plan:
- Order check:
  - Stimulus: out_ready=0; submit ids 1,2,3 with deadlines 50,10,30 on consecutive cycles; then hold out_ready=1.
  - Expected: out_id sequence 2,3,1 back-to-back; out_late=0; pending ends 0.
- Tie-break:
  - Stimulus: submit id 5 (deadline 20) at t=0 and id 6 (deadline 19) at t=1; both have abs_dl=20.
  - Expected: id 5 dispatched first (lower slot index).
- Full table:
  - Stimulus: out_ready=0; submit 9 tasks.
  - Expected: 8 accepted and one loaded to the output; pending=7 after the load, then 8; in_ready=0 at pending=8; the 10th submit stalls until one out_ready pulse.
- Wrap-around:
  - Stimulus: at time_now=0xFFF0, submit id 7 (deadline 0x20, abs_dl 0x0010), then id 8 (deadline 0x08).
  - Expected: id 8 first, then id 7; no false late flag.
- Late flag:
  - Stimulus: out_ready=0; submit id 9 deadline 3; hold 10 cycles; pulse out_ready.
  - Expected: out_id=9 loaded with out_late=0. With EDF_DROP_EXPIRED_EN, a second queued task with deadline 2 is dropped and drop_count=1.
- Mid-operation reset:
  - Stimulus: 4 tasks pending with out_valid=1; assert reset for one cycle.
  - Expected: next cycle out_valid=0, pending=0, time_now=0, in_ready=1.
